// File: rtl/cv32e40p_rf_scrub_pkg.sv
// Shared constants, state encoding and codeword helpers for the register-file
// background scrubber and its Hamming generator.
package cv32e40p_rf_scrub_pkg;

    localparam int unsigned ADDR_WIDTH     = 6;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned PAR_WIDTH      = 6;
    localparam int unsigned CODE_WIDTH     = DATA_WIDTH + PAR_WIDTH;
    localparam int unsigned DEF_NUM_WORDS  = 64;
    localparam int unsigned DEF_CNT_WIDTH  = 16;
    localparam int unsigned INTERVAL_WIDTH = 16;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = 6'd1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        RD   = 3'd2,
        CHK  = 3'd3,
        WB   = 3'd4,
        ADV  = 3'd5
    } scrub_state_e;

    // Codeword positions (1-based) that are powers of two carry parity, the rest carry data.
    function automatic logic is_data_pos(input int unsigned pos);
        return (pos & (pos - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/cv32e40p_hammingGenerator.sv
// Hamming(38,32) encoder: codeword = {parity[5:0], data[31:0]}; parity bit i covers every
// data bit whose 1-based Hamming position has bit i set.
module cv32e40p_hammingGenerator
    import cv32e40p_rf_scrub_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CODE_WIDTH-1:0] code
);

    logic [PAR_WIDTH-1:0] par_s;
    logic [4:0]           idx_s;
    logic                 bit_s;

    // Walk positions 1..38, consuming data bits in order at the non-parity positions.
    always_comb begin
        par_s = '0;
        idx_s = 5'd0;
        bit_s = 1'b0;
        for (int unsigned pos = 1; pos <= CODE_WIDTH; pos++) begin
            bit_s = is_data_pos(pos) & data[idx_s];
            par_s = par_s ^ ({PAR_WIDTH{bit_s}} & pos[PAR_WIDTH-1:0]);
            idx_s = idx_s + {4'd0, is_data_pos(pos)};
        end
    end

    assign code = {par_s, data};

endmodule

// File: rtl/cv32e40p_rf_scrubber.sv
// Background scrubber for the Hamming-protected register file: borrows idle cycles on
// read port C / write port B, re-encodes each entry and writes back corrected words.
module cv32e40p_rf_scrubber
    import cv32e40p_rf_scrub_pkg::*;
#(
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scrub_en_i,
    input  logic [INTERVAL_WIDTH-1:0] interval_i,
    input  logic                      clr_i,
    input  logic                      port_c_busy_i,
    output logic                      rsel_o,
    output logic [ADDR_WIDTH-1:0]     raddr_o,
    input  logic [CODE_WIDTH-1:0]     rdata_raw_i,
    input  logic [DATA_WIDTH-1:0]     rdata_corr_i,
    input  logic                      ded_i,
    input  logic                      core_we_a_i,
    input  logic [ADDR_WIDTH-1:0]     core_waddr_a_i,
    input  logic                      core_we_b_i,
    input  logic [ADDR_WIDTH-1:0]     core_waddr_b_i,
    output logic                      scrub_we_o,
    output logic [ADDR_WIDTH-1:0]     scrub_waddr_o,
    output logic [DATA_WIDTH-1:0]     scrub_wdata_o,
    output logic [CNT_WIDTH-1:0]      sec_cnt_o,
    output logic [CNT_WIDTH-1:0]      ded_cnt_o,
    output logic                      ded_flag_o,
    output logic [ADDR_WIDTH-1:0]     ded_addr_o,
    output logic                      busy_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    scrub_state_e               state_r, state_nx_s;
    logic [ADDR_WIDTH-1:0]      ptr_r, raddr_r, waddr_r, ded_addr_r;
    logic [INTERVAL_WIDTH-1:0]  wait_r;
    logic [CODE_WIDTH-1:0]      raw_r, code_s;
    logic [DATA_WIDTH-1:0]      corr_r;
    logic                       ded_r, abort_r, ded_flag_r, busy_r;
    logic [CNT_WIDTH-1:0]       sec_cnt_r, ded_cnt_r;
    logic                       hit_s, rsel_s, we_s, capture_s, sec_inc_s, ded_evt_s;
    logic                       adv_s, load_wait_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    cv32e40p_hammingGenerator u_gen (
        .data (corr_r),
        .code (code_s)
    );

    // A core write to the entry in flight makes the captured copy stale.
    assign hit_s = (core_we_a_i && (core_waddr_a_i == ptr_r)) ||
                   (core_we_b_i && (core_waddr_b_i == ptr_r));

    // Next-state and per-cycle strobes; disabling the scrubber overrides everything.
    always_comb begin
        state_nx_s  = state_r;
        rsel_s      = 1'b0;
        we_s        = 1'b0;
        capture_s   = 1'b0;
        sec_inc_s   = 1'b0;
        ded_evt_s   = 1'b0;
        adv_s       = 1'b0;
        load_wait_s = 1'b0;
        if (!scrub_en_i) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx_s  = WAIT;
                    load_wait_s = 1'b1;
                end
                WAIT: begin
                    if (wait_r == {INTERVAL_WIDTH{1'b0}}) state_nx_s = RD;
                    else                                  state_nx_s = WAIT;
                end
                RD: begin
                    if (!port_c_busy_i) begin
                        rsel_s     = 1'b1;
                        capture_s  = 1'b1;
                        state_nx_s = CHK;
                    end else begin
                        state_nx_s = RD;
                    end
                end
                CHK: begin
                    if (ded_r) begin
                        ded_evt_s  = 1'b1;
                        state_nx_s = ADV;
                    end else if (abort_r || hit_s) begin
                        state_nx_s = ADV;
                    end else if (code_s != raw_r) begin
                        state_nx_s = WB;
                    end else begin
                        state_nx_s = ADV;
                    end
                end
                WB: begin
                    if (abort_r || hit_s) begin
                        state_nx_s = ADV;
                    end else if (core_we_b_i) begin
                        state_nx_s = WB;
                    end else begin
                        we_s       = 1'b1;
                        sec_inc_s  = 1'b1;
                        state_nx_s = ADV;
                    end
                end
                ADV: begin
                    adv_s       = 1'b1;
                    load_wait_s = 1'b1;
                    state_nx_s  = WAIT;
                end
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State, pointer, captured read data and event bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= FIRST_ADDR;
            raddr_r    <= '0;
            waddr_r    <= '0;
            wait_r     <= '0;
            raw_r      <= '0;
            corr_r     <= '0;
            ded_r      <= 1'b0;
            abort_r    <= 1'b0;
            sec_cnt_r  <= '0;
            ded_cnt_r  <= '0;
            ded_flag_r <= 1'b0;
            ded_addr_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            raddr_r <= ptr_r;
            busy_r  <= (state_nx_s != IDLE) && (state_nx_s != WAIT);
            if (load_wait_s) begin
                wait_r <= interval_i;
            end else if ((state_r == WAIT) && (wait_r != {INTERVAL_WIDTH{1'b0}})) begin
                wait_r <= wait_r - {{(INTERVAL_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                wait_r <= wait_r;
            end
            if (adv_s) begin
                ptr_r <= (ptr_r == LAST_ADDR) ? FIRST_ADDR : ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                ptr_r <= ptr_r;
            end
            if (capture_s) begin
                raw_r   <= rdata_raw_i;
                corr_r  <= rdata_corr_i;
                ded_r   <= ded_i;
                waddr_r <= ptr_r;
                abort_r <= hit_s;
            end else if ((state_r == CHK) || (state_r == WB)) begin
                abort_r <= abort_r | hit_s;
            end else begin
                abort_r <= 1'b0;
            end
            if (clr_i) begin
                sec_cnt_r  <= '0;
                ded_cnt_r  <= '0;
                ded_flag_r <= 1'b0;
            end else begin
                sec_cnt_r  <= sec_inc_s ? sat_inc(sec_cnt_r) : sec_cnt_r;
                ded_cnt_r  <= ded_evt_s ? sat_inc(ded_cnt_r) : ded_cnt_r;
                ded_flag_r <= ded_flag_r | ded_evt_s;
            end
            if (ded_evt_s) begin
                ded_addr_r <= ptr_r;
            end else begin
                ded_addr_r <= ded_addr_r;
            end
        end
    end

    assign rsel_o        = rsel_s & ~rst;
    assign scrub_we_o    = we_s & ~rst;
    assign raddr_o       = raddr_r;
    assign scrub_waddr_o = waddr_r;
    assign scrub_wdata_o = corr_r;
    assign sec_cnt_o     = sec_cnt_r;
    assign ded_cnt_o     = ded_cnt_r;
    assign ded_flag_o    = ded_flag_r;
    assign ded_addr_o    = ded_addr_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_cv32e40p_rf_scrubber.sv
// Directed bench for the register-file scrubber with a behavioural RF / port-C checker
// model and a write-back scoreboard.
module tb_cv32e40p_rf_scrubber;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, scrub_en, clr, port_c_busy;
    logic [15:0]      interval;
    logic             core_we_a, core_we_b;
    logic [5:0]       core_waddr_a, core_waddr_b;
    logic [31:0]      core_wdata_a, core_wdata_b;
    logic             rsel, scrub_we, ded_flag, busy;
    logic [5:0]       raddr, scrub_waddr, ded_addr;
    logic [31:0]      scrub_wdata;
    logic [CNT_W-1:0] sec_cnt, ded_cnt;
    logic [37:0]      rdata_raw;
    logic [31:0]      rdata_corr;
    logic             ded;

    logic [37:0] code_mem [64];
    logic [31:0] data_mem [64];
    logic        ded_mem  [64];
    logic [31:0] pmask    [6];

    sb_t exp_q[$];
    int  visits[$];
    int  cyc, n_pass, n_total, n_fail, wr_cnt, last_wr_cyc, last_vis_cyc;
    logic vis_now;

    assign rdata_raw  = code_mem[raddr];
    assign rdata_corr = data_mem[raddr];
    assign ded        = ded_mem[raddr];

    cv32e40p_rf_scrubber #(.CNT_WIDTH(CNT_W)) dut (
        .clk(clk), .rst(rst), .scrub_en_i(scrub_en), .interval_i(interval), .clr_i(clr),
        .port_c_busy_i(port_c_busy), .rsel_o(rsel), .raddr_o(raddr),
        .rdata_raw_i(rdata_raw), .rdata_corr_i(rdata_corr), .ded_i(ded),
        .core_we_a_i(core_we_a), .core_waddr_a_i(core_waddr_a),
        .core_we_b_i(core_we_b), .core_waddr_b_i(core_waddr_b),
        .scrub_we_o(scrub_we), .scrub_waddr_o(scrub_waddr), .scrub_wdata_o(scrub_wdata),
        .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt), .ded_flag_o(ded_flag),
        .ded_addr_o(ded_addr), .busy_o(busy)
    );

    function automatic logic [37:0] enc(input logic [31:0] d);
        logic [5:0] p;
        for (int i = 0; i < 6; i++) p[i] = ^(d & pmask[i]);
        return {p, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score write-backs, update the RF model.
    task automatic step();
        sb_t e;
        @(negedge clk);
        cyc++;
        vis_now = rsel;
        if (rsel) begin
            visits.push_back(int'(raddr));
            last_vis_cyc = cyc;
        end
        if (scrub_we) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            check("wb_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wb_addr", 64'(scrub_waddr), 64'(e.addr));
                check("wb_data", 64'(scrub_wdata), 64'(e.data));
            end
            data_mem[scrub_waddr] = scrub_wdata;
            code_mem[scrub_waddr] = enc(scrub_wdata);
            ded_mem[scrub_waddr]  = 1'b0;
        end
        if (core_we_a) begin
            data_mem[core_waddr_a] = core_wdata_a;
            code_mem[core_waddr_a] = enc(core_wdata_a);
            ded_mem[core_waddr_a]  = 1'b0;
        end
        if (core_we_b) begin
            data_mem[core_waddr_b] = core_wdata_b;
            code_mem[core_waddr_b] = enc(core_wdata_b);
            ded_mem[core_waddr_b]  = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_visit(input int a, output int vc);
        logic found;
        found = 1'b0;
        vc = -1;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (vis_now && (int'(raddr) == a)) begin
                found = 1'b1;
                vc = cyc;
            end
        end
        check($sformatf("visit_%0d_seen", a), 64'(found), 64'd1);
    endtask

    task automatic inject(input int a, input logic [37:0] mask, input logic dbl);
        code_mem[a] = code_mem[a] ^ mask;
        ded_mem[a]  = dbl;
    endtask

    task automatic push_wb(input int a);
        sb_t e;
        e.addr = 6'(a);
        e.data = data_mem[a];
        exp_q.push_back(e);
    endtask

    initial begin
        int k, v, w0, owned, n0;
        cyc = 0; n_pass = 0; n_total = 0; n_fail = 0; wr_cnt = 0;
        last_wr_cyc = -1; last_vis_cyc = -1; vis_now = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) pmask[i] = 32'd0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int i = 0; i < 6; i++) if (pos[i]) pmask[i][k] = 1'b1;
                k++;
            end
        end
        for (int i = 0; i < 64; i++) begin
            data_mem[i] = (32'h9E37_79B9 * 32'(i)) ^ 32'hC0DE_0000;
            code_mem[i] = enc(data_mem[i]);
            ded_mem[i]  = 1'b0;
        end
        rst = 1'b1; scrub_en = 1'b0; clr = 1'b0; port_c_busy = 1'b0; interval = 16'd0;
        core_we_a = 1'b0; core_we_b = 1'b0; core_waddr_a = 6'd0; core_waddr_b = 6'd0;
        core_wdata_a = 32'd0; core_wdata_b = 32'd0;

        // Reset state
        repeat (3) step();
        check("rst_rsel", 64'(rsel), 64'd0);
        check("rst_raddr", 64'(raddr), 64'd0);
        check("rst_we", 64'(scrub_we), 64'd0);
        check("rst_waddr", 64'(scrub_waddr), 64'd0);
        check("rst_wdata", 64'(scrub_wdata), 64'd0);
        check("rst_sec", 64'(sec_cnt), 64'd0);
        check("rst_ded", 64'(ded_cnt), 64'd0);
        check("rst_flag", 64'(ded_flag), 64'd0);
        check("rst_dedaddr", 64'(ded_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // 1: clean sweep 1..63 then wrap to 1
        rst = 1'b0; scrub_en = 1'b1;
        for (int i = 0; i < 400 && visits.size() < 64; i++) step();
        for (int i = 0; i < 64; i++)
            check($sformatf("sweep_%0d", i), 64'((i < visits.size()) ? visits[i] : -1), 64'((i % 63) + 1));
        check("clean_writes", 64'(wr_cnt), 64'd0);
        check("clean_sec", 64'(sec_cnt), 64'd0);
        check("clean_ded", 64'(ded_cnt), 64'd0);

        // 2: single-bit error at entry 5
        inject(5, 38'd1 << 9, 1'b0);
        push_wb(5);
        wait_visit(5, v);
        repeat (3) step();
        check("sec5_wr_cycle", 64'(last_wr_cyc), 64'(v + 2));
        check("sec5_cnt", 64'(sec_cnt), 64'd1);
        check("sec5_sb_empty", 64'(exp_q.size()), 64'd0);
        w0 = wr_cnt;
        wait_visit(5, v);
        repeat (3) step();
        check("rescan5_no_wr", 64'(wr_cnt), 64'(w0));
        check("rescan5_sec", 64'(sec_cnt), 64'd1);

        // 3: double-bit error at entry 7
        inject(7, (38'd1 << 3) | (38'd1 << 20), 1'b1);
        wait_visit(7, v);
        repeat (3) step();
        check("ded7_cnt", 64'(ded_cnt), 64'd1);
        check("ded7_flag", 64'(ded_flag), 64'd1);
        check("ded7_addr", 64'(ded_addr), 64'd7);
        check("ded7_no_wr", 64'(wr_cnt), 64'(w0));
        check("ded7_sec", 64'(sec_cnt), 64'd1);
        code_mem[7] = enc(data_mem[7]);
        ded_mem[7]  = 1'b0;

        // 4a: SEC at 12 with port B busy for 4 WB cycles
        inject(12, 38'd1 << 0, 1'b0);
        push_wb(12);
        wait_visit(12, v);
        step();
        core_we_b = 1'b1; core_waddr_b = 6'd40; core_wdata_b = 32'h0BAD_F00D;
        repeat (4) step();
        core_we_b = 1'b0;
        step();
        check("wb12_stall_cycle", 64'(last_wr_cyc), 64'(v + 6));
        repeat (2) step();
        check("wb12_sec", 64'(sec_cnt), 64'd2);
        check("wb12_sb_empty", 64'(exp_q.size()), 64'd0);

        // 4b: core port-A write to 12 during WB drops the write-back
        inject(12, 38'd1 << 30, 1'b0);
        w0 = wr_cnt;
        wait_visit(12, v);
        step();
        core_we_a = 1'b1; core_waddr_a = 6'd12; core_wdata_a = 32'h1357_9BDF;
        step();
        core_we_a = 1'b0;
        repeat (3) step();
        check("abort12_no_wr", 64'(wr_cnt), 64'(w0));
        check("abort12_sec", 64'(sec_cnt), 64'd2);

        // 5: port C busy for 10 cycles in RD
        wait_visit(20, v);
        n0 = visits.size();
        port_c_busy = 1'b1;
        owned = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            owned += int'(vis_now);
        end
        check("busy_rsel_low", 64'(owned), 64'd0);
        check("busy_no_visit", 64'(visits.size()), 64'(n0));
        check("busy_in_rd", 64'(busy), 64'd1);
        port_c_busy = 1'b0;
        step();
        check("busy_read_now", 64'(vis_now), 64'd1);
        check("busy_read_addr", 64'(raddr), 64'd21);
        check("busy_read_cycle", 64'(last_vis_cyc), 64'(v + 14));

        // 6: saturation, clear, reset during WB
        for (int a = 30; a <= 43; a++) begin
            inject(a, 38'd1 << (a - 28), 1'b0);
            push_wb(a);
        end
        wait_visit(43, v);
        repeat (3) step();
        check("sat_sec", 64'(sec_cnt), 64'(4'hF));
        check("sat_sb_empty", 64'(exp_q.size()), 64'd0);
        check("preclr_ded", 64'(ded_cnt), 64'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_sec", 64'(sec_cnt), 64'd0);
        check("clr_ded", 64'(ded_cnt), 64'd0);
        check("clr_flag", 64'(ded_flag), 64'd0);

        inject(50, 38'd1 << 33, 1'b0);
        w0 = wr_cnt;
        wait_visit(50, v);
        step();
        rst = 1'b1;
        step();
        step();
        check("rstwb_no_wr", 64'(wr_cnt), 64'(w0));
        check("rstwb_busy", 64'(busy), 64'd0);
        check("rstwb_raddr", 64'(raddr), 64'd0);
        check("rstwb_sec", 64'(sec_cnt), 64'd0);
        rst = 1'b0;
        wait_visit(1, v);
        check("restart_addr", 64'(raddr), 64'd1);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
